// File: rtl/hazard_scoreboard_if.sv
// Hazard unit bundle: pipeline addresses/controls and multi-cycle unit status in, stalls/flushes/forwarding out.
// Latency: the interface is wiring only. The outputs follow the inputs combinationally.
// Backpressure: none inside the bundle. The stall, flush and FUAck outputs are the backpressure.
interface hazard_scoreboard_if #(
    parameter int ADDR_W = 4,
    parameter int NUM_FU = 2,
    parameter int CNT_W  = 32
);
    localparam int SEL_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [ADDR_W-1:0]        RA1D, RA2D, WA3D;
    logic [ADDR_W-1:0]        RA1E, RA2E, WA3E;
    logic [ADDR_W-1:0]        RA2M, WA3M, WA3W;
    logic                     RegWriteE, RegWriteM, RegWriteW;
    logic                     MemtoRegE, MemWriteM, MemtoRegW;
    logic                     PCSrcE;
    logic [NUM_FU-1:0]        FUReqD, FUStartE, FUBusy, FUDone;
    logic [NUM_FU*ADDR_W-1:0] FUWA3;
    logic                     MemReqM, CacheReady, CntClr;

    logic [1:0]               ForwardAE, ForwardBE;
    logic                     ForwardM;
    logic                     StallF, StallD, StallE, StallM, StallW, FlushD, FlushE;
    logic [NUM_FU-1:0]        FUAck;
    logic [SEL_W-1:0]         FUWbSel;
    logic [(1<<ADDR_W)-1:0]   Pending;
    logic [CNT_W-1:0]         StallCycles;

    // Pipeline/datapath side
    modport master (
        output RA1D, RA2D, WA3D, RA1E, RA2E, WA3E, RA2M, WA3M, WA3W,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemWriteM, MemtoRegW,
               PCSrcE, FUReqD, FUStartE, FUBusy, FUDone, FUWA3, MemReqM, CacheReady, CntClr,
        input  ForwardAE, ForwardBE, ForwardM, StallF, StallD, StallE, StallM, StallW,
               FlushD, FlushE, FUAck, FUWbSel, Pending, StallCycles
    );

    // Hazard unit side
    modport slave (
        input  RA1D, RA2D, WA3D, RA1E, RA2E, WA3E, RA2M, WA3M, WA3W,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemWriteM, MemtoRegW,
               PCSrcE, FUReqD, FUStartE, FUBusy, FUDone, FUWA3, MemReqM, CacheReady, CntClr,
        output ForwardAE, ForwardBE, ForwardM, StallF, StallD, StallE, StallM, StallW,
               FlushD, FlushE, FUAck, FUWbSel, Pending, StallCycles
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard unit: forwarding, load-use and scoreboard stalls, and round-robin writeback grant for multi-cycle units.
// Latency: every output is combinational. Pending and StallCycles update on the next rising CLK edge.
// Backpressure: a cache miss freezes the whole pipe and blocks grants. Writeback grants steal a decode slot.
module hazard_scoreboard #(
    parameter int ADDR_W = 4,
    parameter int NUM_FU = 2,
    parameter int CNT_W  = 32
) (
    input logic                CLK,
    input logic                RESET,
    hazard_scoreboard_if.slave hs
);
    localparam int SEL_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int NREG  = 1 << ADDR_W;

    logic [NREG-1:0]   pend, pend_nxt;
    logic [SEL_W-1:0]  owner [NREG];
    logic [SEL_W-1:0]  owner_nxt [NREG];
    logic [SEL_W-1:0]  rr, gnt_idx;
    logic              gnt_vld, ack_en, start_hit;
    logic [NUM_FU-1:0] ack;
    logic [CNT_W-1:0]  stall_cnt;
    logic              ldrstall, sbstall, wbsteal, cachestall, stall_fd;

    function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_FU) s = s - NUM_FU;
        return SEL_W'(s);
    endfunction

    // Forwarding stays live during reset
    always_comb begin
        hs.ForwardAE = 2'b00;
        hs.ForwardBE = 2'b00;
        if (hs.RegWriteM && hs.RA1E == hs.WA3M)      hs.ForwardAE = 2'b10;
        else if (hs.RegWriteW && hs.RA1E == hs.WA3W) hs.ForwardAE = 2'b01;
        if (hs.RegWriteM && hs.RA2E == hs.WA3M)      hs.ForwardBE = 2'b10;
        else if (hs.RegWriteW && hs.RA2E == hs.WA3W) hs.ForwardBE = 2'b01;
    end

    assign hs.ForwardM = (hs.RA2M == hs.WA3W) & hs.MemWriteM & hs.MemtoRegW & hs.RegWriteW;

    assign ldrstall   = ((hs.RA1D == hs.WA3E) | (hs.RA2D == hs.WA3E)) & hs.MemtoRegE & hs.RegWriteE;
    assign sbstall    = pend[hs.RA1D] | pend[hs.RA2D] | pend[hs.WA3D] | (|(hs.FUReqD & hs.FUBusy));
    assign cachestall = hs.MemReqM & ~hs.CacheReady & ~RESET;

    // Round-robin search starting at rr
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (!gnt_vld && hs.FUDone[wrap_idx(rr, k)]) begin
                gnt_vld = 1'b1;
                gnt_idx = wrap_idx(rr, k);
            end
        end
    end

    assign ack_en = gnt_vld & ~cachestall & ~RESET;

    always_comb begin
        ack = '0;
        if (ack_en) ack[gnt_idx] = 1'b1;
    end

    assign hs.FUAck   = ack;
    assign hs.FUWbSel = ack_en ? gnt_idx : '0;
    assign wbsteal    = (|ack) & ~hs.PCSrcE;
    assign stall_fd   = (ldrstall | sbstall | wbsteal | cachestall) & ~RESET;

    assign hs.StallF = stall_fd;
    assign hs.StallD = stall_fd;
    assign hs.StallE = cachestall;
    assign hs.StallM = cachestall;
    assign hs.StallW = cachestall;
    assign hs.FlushD = hs.PCSrcE & ~RESET;
    assign hs.FlushE = (ldrstall | sbstall | wbsteal | hs.PCSrcE) & ~cachestall & ~RESET;

    // Clears are applied first so that a same-edge start on that register wins.
    // A stale ack from a unit that lost ownership leaves the bit alone.
    always_comb begin
        pend_nxt  = pend;
        owner_nxt = owner;
        start_hit = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (ack[i] && owner[hs.FUWA3[i*ADDR_W +: ADDR_W]] == SEL_W'(i))
                pend_nxt[hs.FUWA3[i*ADDR_W +: ADDR_W]] = 1'b0;
        end
        for (int i = 0; i < NUM_FU; i++) begin
            if (!start_hit && hs.FUStartE[i]) begin
                start_hit           = 1'b1;
                pend_nxt[hs.WA3E]  = 1'b1;
                owner_nxt[hs.WA3E] = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pend      <= '0;
            rr        <= '0;
            stall_cnt <= '0;
            for (int r = 0; r < NREG; r++) owner[r] <= '0;
        end else begin
            pend  <= pend_nxt;
            owner <= owner_nxt;
            if (ack_en) rr <= wrap_idx(gnt_idx, 1);
            if (hs.CntClr)                    stall_cnt <= '0;
            else if (stall_fd && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign hs.Pending     = pend;
    assign hs.StallCycles = stall_cnt;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with ADDR_W=4, NUM_FU=2 and CNT_W=4, using hand-computed expected values.
// Inputs are driven 1 time unit after a rising edge. Outputs are checked 1 unit later, well clear of the edges.
module tb_hazard_scoreboard;
    logic CLK = 1'b0;
    logic RESET;
    int   n_tests = 0;
    int   n_fail  = 0;

    hazard_scoreboard_if #(.ADDR_W(4), .NUM_FU(2), .CNT_W(4)) hif();

    hazard_scoreboard #(.ADDR_W(4), .NUM_FU(2), .CNT_W(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .hs    (hif.slave)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        hif.RA1D = '0; hif.RA2D = '0; hif.WA3D = '0;
        hif.RA1E = '0; hif.RA2E = '0; hif.WA3E = '0;
        hif.RA2M = '0; hif.WA3M = '0; hif.WA3W = '0;
        hif.RegWriteE = 0; hif.RegWriteM = 0; hif.RegWriteW = 0;
        hif.MemtoRegE = 0; hif.MemWriteM = 0; hif.MemtoRegW = 0;
        hif.PCSrcE = 0; hif.FUReqD = '0; hif.FUStartE = '0; hif.FUBusy = '0;
        hif.FUDone = '0; hif.FUWA3 = '0; hif.MemReqM = 0; hif.CacheReady = 0; hif.CntClr = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        RESET = 1'b1;
        #2;
        RESET = 1'b0;
        #1;
    endtask

    initial begin
        // Reset state. Stalls, flushes and grants are held low, and forwarding stays live.
        clear_inputs();
        RESET = 1'b1;
        hif.FUDone = 2'b01; hif.FUReqD = 2'b01; hif.FUBusy = 2'b01; hif.PCSrcE = 1;
        hif.MemReqM = 1; hif.RA1E = 4'd3; hif.WA3M = 4'd3; hif.RegWriteM = 1;
        #2;
        chk("rst_stallf",  32'(hif.StallF), 0);
        chk("rst_stalle",  32'(hif.StallE), 0);
        chk("rst_flushd",  32'(hif.FlushD), 0);
        chk("rst_flushe",  32'(hif.FlushE), 0);
        chk("rst_ack",     32'(hif.FUAck), 0);
        chk("rst_fwda",    32'(hif.ForwardAE), 2);
        tick();
        chk("rst_pend",    32'(hif.Pending), 0);
        chk("rst_cnt",     32'(hif.StallCycles), 0);
        clear_inputs();
        RESET = 1'b0;
        settle();

        // Forwarding priority, then ForwardM
        hif.RA1E = 4'd3; hif.WA3M = 4'd3; hif.RegWriteM = 1; hif.WA3W = 4'd3; hif.RegWriteW = 1;
        settle(); chk("fwda_m_over_w", 32'(hif.ForwardAE), 2);
        hif.RegWriteM = 0;
        settle(); chk("fwda_w", 32'(hif.ForwardAE), 1);
        hif.RegWriteW = 0;
        settle(); chk("fwda_rf", 32'(hif.ForwardAE), 0);
        hif.RA2E = 4'd0; hif.WA3W = 4'd0; hif.RegWriteW = 1;
        settle(); chk("fwdb_w_r0", 32'(hif.ForwardBE), 1);
        hif.RA2M = 4'd9; hif.WA3W = 4'd9; hif.MemWriteM = 1; hif.MemtoRegW = 1;
        settle(); chk("fwdm_on", 32'(hif.ForwardM), 1);
        hif.MemtoRegW = 0;
        settle(); chk("fwdm_off", 32'(hif.ForwardM), 0);

        // Load-use stall and branch flush
        clear_inputs();
        hif.RA2D = 4'd6; hif.WA3E = 4'd6; hif.MemtoRegE = 1; hif.RegWriteE = 1;
        settle();
        chk("ldr_stallf", 32'(hif.StallF), 1);
        chk("ldr_stalld", 32'(hif.StallD), 1);
        chk("ldr_flushe", 32'(hif.FlushE), 1);
        chk("ldr_stalle", 32'(hif.StallE), 0);
        hif.PCSrcE = 1;
        settle(); chk("br_flushd", 32'(hif.FlushD), 1);

        // Scoreboard hazard on r5 owned by unit 0
        do_reset();
        hif.FUStartE = 2'b01; hif.WA3E = 4'd5;
        tick();
        hif.FUStartE = 2'b00; hif.WA3E = 4'd0; hif.RA1D = 4'd5;
        settle();
        chk("sb_pend5",   32'(hif.Pending[5]), 1);
        chk("sb_stallf",  32'(hif.StallF), 1);
        chk("sb_stalld",  32'(hif.StallD), 1);
        chk("sb_flushe",  32'(hif.FlushE), 1);
        tick();
        chk("sb_hold", 32'(hif.StallF), 1);
        hif.FUDone = 2'b01; hif.FUWA3 = {4'd0, 4'd5};
        settle();
        chk("sb_ack",    32'(hif.FUAck), 1);
        chk("sb_sel",    32'(hif.FUWbSel), 0);
        chk("sb_ack_st", 32'(hif.StallF), 1);
        tick();
        hif.FUDone = 2'b00;
        settle();
        chk("sb_clr5",    32'(hif.Pending[5]), 0);
        chk("sb_release", 32'(hif.StallF), 0);
        chk("sb_cnt",     32'(hif.StallCycles), 2);

        // Same-edge clear by unit 0 and set by unit 1. The set wins, and the stale ack is then ignored.
        hif.RA1D = 4'd0; hif.FUStartE = 2'b01; hif.WA3E = 4'd8;
        tick();
        hif.FUDone = 2'b01; hif.FUWA3 = {4'd0, 4'd8}; hif.FUStartE = 2'b10;
        settle(); chk("se_ack0", 32'(hif.FUAck), 1);
        tick();
        hif.FUStartE = 2'b00;
        settle(); chk("se_setwins", 32'(hif.Pending[8]), 1);
        tick();
        chk("se_stale_ack", 32'(hif.Pending[8]), 1);
        hif.FUDone = 2'b10; hif.FUWA3 = {4'd8, 4'd0};
        settle(); chk("se_ack1", 32'(hif.FUAck), 2);
        tick();
        hif.FUDone = 2'b00;
        settle(); chk("se_clr8", 32'(hif.Pending[8]), 0);

        // Round-robin with both units done
        do_reset();
        hif.FUDone = 2'b11;
        for (int c = 0; c < 4; c++) begin
            settle();
            chk("rr_ack",    32'(hif.FUAck), (c % 2 == 0) ? 1 : 2);
            chk("rr_sel",    32'(hif.FUWbSel), (c % 2 == 0) ? 0 : 1);
            chk("rr_wbstl",  32'(hif.StallF), 1);
            tick();
        end
        hif.PCSrcE = 1;
        settle();
        chk("rr_br_nostall", 32'(hif.StallF), 0);
        chk("rr_br_flushe",  32'(hif.FlushE), 1);

        // A cache miss freezes everything and blocks the grant
        do_reset();
        hif.MemReqM = 1; hif.CacheReady = 0; hif.FUDone = 2'b01;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("cm_stallf", 32'(hif.StallF), 1);
            chk("cm_stalle", 32'(hif.StallE), 1);
            chk("cm_stallm", 32'(hif.StallM), 1);
            chk("cm_stallw", 32'(hif.StallW), 1);
            chk("cm_flushe", 32'(hif.FlushE), 0);
            chk("cm_ack",    32'(hif.FUAck), 0);
            tick();
        end
        hif.CacheReady = 1;
        settle();
        chk("cm_grant",  32'(hif.FUAck), 1);
        chk("cm_unfrz",  32'(hif.StallE), 0);

        // r7 started by unit 0 and then by unit 1. Only unit 1's ack clears it.
        do_reset();
        hif.FUStartE = 2'b01; hif.WA3E = 4'd7;
        tick();
        hif.FUStartE = 2'b10;
        tick();
        hif.FUStartE = 2'b00; hif.WA3E = 4'd0;
        hif.FUDone = 2'b01; hif.FUWA3 = {4'd7, 4'd7};
        settle(); chk("own_ack0", 32'(hif.FUAck), 1);
        tick();
        chk("own_keep7", 32'(hif.Pending[7]), 1);
        hif.FUDone = 2'b10;
        settle(); chk("own_ack1", 32'(hif.FUAck), 2);
        tick();
        hif.FUDone = 2'b00;
        settle(); chk("own_clr7", 32'(hif.Pending[7]), 0);

        // Stall counter saturation, clear priority, and reset in mid-stall
        do_reset();
        hif.FUReqD = 2'b01; hif.FUBusy = 2'b01;
        repeat (3) tick();
        chk("cnt_3", 32'(hif.StallCycles), 3);
        repeat (17) tick();
        chk("cnt_sat", 32'(hif.StallCycles), 15);
        hif.CntClr = 1;
        tick();
        chk("cnt_clr", 32'(hif.StallCycles), 0);
        hif.CntClr = 0;
        tick();
        chk("cnt_restart", 32'(hif.StallCycles), 1);
        hif.FUStartE = 2'b01; hif.WA3E = 4'd2;
        tick();
        hif.FUStartE = 2'b00; hif.FUDone = 2'b01; hif.FUWA3 = {4'd0, 4'd2};
        chk("mr_pend2", 32'(hif.Pending[2]), 1);
        #2;
        RESET = 1'b1;
        #1;
        chk("mr_pend",   32'(hif.Pending), 0);
        chk("mr_cnt",    32'(hif.StallCycles), 0);
        chk("mr_stallf", 32'(hif.StallF), 0);
        chk("mr_ack",    32'(hif.FUAck), 0);
        RESET = 1'b0;
        hif.FUReqD = 2'b00; hif.FUBusy = 2'b00;
        settle();
        chk("mr_late_ack", 32'(hif.FUAck), 1);
        tick();
        hif.FUDone = 2'b00;
        chk("mr_harmless", 32'(hif.Pending), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
